// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state encodings and grid constants for the snake engine
package snake_pkg;
   localparam int POS_W   = 6;
   localparam int COORD_W = 3;
   localparam logic [COORD_W-1:0] GRID_MAX = 3'd7;
   typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
   typedef enum logic [1:0] {RUN, MOVE, CHECK, DEAD} state_t;
   function automatic dir_t reverse(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction
endpackage

// File: rtl/snake_next_pos.sv
// snake_next_pos: head advanced one cell with 3-bit wrap, plus edge-crossing flag
module snake_next_pos
   import snake_pkg::*;
(
   input  logic [POS_W-1:0] head,
   input  dir_t             cur_dir,
   output logic [POS_W-1:0] nxt,
   output logic             out_of_bounds
);
   logic [COORD_W-1:0] x, y;
   assign x = head[POS_W-1:COORD_W];
   assign y = head[COORD_W-1:0];
   always_comb begin
      nxt = cur_dir == DIR_UP    ? {x, y - 3'd1} :
            cur_dir == DIR_RIGHT ? {x + 3'd1, y} :
            cur_dir == DIR_DOWN  ? {x, y + 3'd1} : {x - 3'd1, y};
      out_of_bounds = (cur_dir == DIR_UP    && y == '0) ||
                      (cur_dir == DIR_RIGHT && x == GRID_MAX) ||
                      (cur_dir == DIR_DOWN  && y == GRID_MAX) ||
                      (cur_dir == DIR_LEFT  && x == '0);
   end
endmodule

// File: rtl/snake_body.sv
// snake_body: snake segment list, movement, growth and self-collision; WALL_KILL_EN makes leaving the grid fatal
module snake_body
   import snake_pkg::*;
#(
   parameter int MAX_LEN   = 16,
   parameter int START_LEN = 3,
   parameter int START_X   = 3,
   parameter int START_Y   = 4,
   localparam int AW = $clog2(MAX_LEN),
   localparam int LW = AW + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             step,
   input  logic [1:0]       dir,
   input  logic [6:0]       food,
   output logic             gen,
   output logic [POS_W-1:0] head,
   output logic [LW-1:0]    length,
   input  logic [AW-1:0]    seg_addr,
   output logic [POS_W-1:0] seg_pos,
   output logic             seg_valid,
   output logic             game_over
);
`ifdef WALL_KILL_EN
   localparam bit WALL_KILL = 1'b1;
`else
   localparam bit WALL_KILL = 1'b0;
`endif
   state_t state, state_n;
   dir_t cur_dir;
   logic [POS_W-1:0] seg [MAX_LEN];
   logic [POS_W-1:0] nxt;
   logic oob, wall_hit, hit, eat, unused_food;
   snake_next_pos u_next (.head(seg[0]), .cur_dir(cur_dir), .nxt(nxt), .out_of_bounds(oob));
   assign wall_hit = WALL_KILL && oob;
   assign eat = seg[0] == food[POS_W-1:0];
   assign unused_food = food[6];
   assign head = seg[0];
   assign seg_pos = seg[seg_addr];
   assign seg_valid = LW'(seg_addr) < length;
   // body excludes index L: that slot holds the tail that just moved away
   always_comb begin
      hit = 1'b0;
      for (int i = 1; i < MAX_LEN; i++)
         if (LW'(i) < length && seg[i] == seg[0]) hit = 1'b1;
   end
   always_ff @(posedge CLK) state <= RST ? RUN : state_n;
   always_comb
      state_n = state == RUN   ? (step ? MOVE : RUN) :
                state == MOVE  ? (wall_hit ? DEAD : CHECK) :
                state == CHECK ? (hit ? DEAD : RUN) : DEAD;
   always_comb game_over = state == DEAD;
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < MAX_LEN; i++) seg[i] <= {COORD_W'(START_X - i), COORD_W'(START_Y)};
         cur_dir <= DIR_RIGHT;
         length <= LW'(START_LEN);
         gen <= 1'b0;
      end else begin
         gen <= state == CHECK && !hit && eat;
         if (state == RUN && step && dir_t'(dir) != reverse(cur_dir)) cur_dir <= dir_t'(dir);
         if (state == MOVE && !wall_hit) begin
            for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
            seg[0] <= nxt;
         end
         if (state == CHECK && !hit && eat && length != LW'(MAX_LEN)) length <= length + LW'(1);
      end
   end
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed + randomized checks of snake_body against a queue-based snake model
module tb_snake_body;
   localparam int MAX = 16, START_LEN = 3, START_X = 3, START_Y = 4;
   logic CLK, RST, step, gen, seg_valid, game_over;
   logic [1:0] dir;
   logic [6:0] food;
   logic [5:0] head, seg_pos;
   logic [4:0] length;
   logic [3:0] seg_addr;
   logic [5:0] body [$];
   int cdir, errors, checks;
   bit dead_m;

   snake_body #(.MAX_LEN(MAX), .START_LEN(START_LEN), .START_X(START_X), .START_Y(START_Y)) dut (
      .CLK(CLK), .RST(RST), .step(step), .dir(dir), .food(food), .gen(gen), .head(head),
      .length(length), .seg_addr(seg_addr), .seg_pos(seg_pos), .seg_valid(seg_valid),
      .game_over(game_over)
   );

   initial CLK = 1'b0;
   always #20 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_segs;
      for (int i = 0; i < MAX; i++) begin
         seg_addr = 4'(i);
         #1;
         chk($sformatf("seg_valid[%0d]", i), seg_valid, i < body.size());
         if (i < body.size()) chk($sformatf("seg_pos[%0d]", i), seg_pos, body[i]);
      end
   endtask

   task automatic model_reset;
      body.delete();
      for (int i = 0; i < START_LEN; i++) body.push_back({3'(START_X - i), 3'(START_Y)});
      cdir = 1;
      dead_m = 1'b0;
   endtask

   task automatic do_reset;
      RST = 1'b1;
      step = 1'($urandom);
      tick;
      RST = 1'b0;
      step = 1'b0;
      model_reset();
      chk("rst_head", head, 6'o34);
      chk("rst_len", length, 3);
      chk("rst_gen", gen, 0);
      chk("rst_go", game_over, 0);
      check_segs();
   endtask

   // mode: 0 random food, 1 food on the next head, 2 food never on the next head
   task automatic do_step(input int d, input int mode);
      int x, y, ox, oy;
      logic [5:0] nh;
      logic [6:0] fd;
      bit hit_e, eat_e, wall_e;
      if (dead_m) begin
         dir = 2'(d);
         step = 1'b1;
         tick;
         step = 1'b0;
         tick;
         tick;
         chk("dead_head", head, body[0]);
         chk("dead_len", length, body.size());
         chk("dead_go", game_over, 1);
         chk("dead_gen", gen, 0);
         return;
      end
      if (d != (cdir + 2) % 4) cdir = d;
      ox = int'(body[0][5:3]);
      oy = int'(body[0][2:0]);
      x = ox;
      y = oy;
      case (cdir)
         0: y = (oy + 7) % 8;
         1: x = (ox + 1) % 8;
         2: y = (oy + 1) % 8;
         default: x = (ox + 7) % 8;
      endcase
      nh = {3'(x), 3'(y)};
      wall_e = 1'b0;
`ifdef WALL_KILL_EN
      wall_e = (cdir == 0 && oy == 0) || (cdir == 1 && ox == 7) || (cdir == 2 && oy == 7) || (cdir == 3 && ox == 0);
`endif
      hit_e = 1'b0;
      for (int i = 0; i < body.size() - 1; i++) if (body[i] == nh) hit_e = 1'b1;
      fd = mode == 1 ? {1'($urandom), nh} : mode == 2 ? {1'($urandom), ~nh} : 7'($urandom);
      eat_e = !wall_e && !hit_e && fd[5:0] == nh;
      dir = 2'(d);
      step = 1'b1;
      food = 7'($urandom);
      tick;
      dir = 2'($urandom);
      step = 1'($urandom);
      food = 7'($urandom);
      tick;
      food = fd;
      step = 1'($urandom);
      chk("mid_gen", gen, 0);
      if (wall_e) begin
         chk("wall_head", head, body[0]);
         chk("wall_go", game_over, 1);
      end else chk("move_head", head, nh);
      tick;
      step = 1'b0;
      food = 7'($urandom);
      if (wall_e) dead_m = 1'b1;
      else begin
         if (hit_e) dead_m = 1'b1;
         body.push_front(nh);
         if (!(eat_e && body.size() <= MAX)) void'(body.pop_back());
      end
      chk("gen_pulse", gen, eat_e);
      chk("step_len", length, body.size());
      chk("step_go", game_over, dead_m);
      chk("step_head", head, body[0]);
      tick;
      chk("gen_clear", gen, 0);
      check_segs();
   endtask

   initial begin
      int path [20] = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 3, 3, 2, 1, 1, 1, 1, 1, 1, 1};
      errors = 0;
      checks = 0;
      RST = 1'b1;
      step = 1'b0;
      dir = 2'd0;
      food = 7'd0;
      seg_addr = 4'd0;
      tick;
      do_reset();
      seg_addr = 4'd1;
      #1 chk("rst_seg1", seg_pos, 6'o24);
      seg_addr = 4'd2;
      #1 chk("rst_seg2", seg_pos, 6'o14);
      do_step(3, 2);
      chk("reverse_ignored", head, 6'o44);
      do_step(0, 2);
      chk("turn_up", head, 6'o43);
      do_reset();
      do_step(1, 2);
      do_step(1, 1);
      chk("eat_head", head, 6'o54);
      chk("eat_len", length, 4);
      seg_addr = 4'd3;
      #1 chk("eat_seg3", seg_pos, 6'o24);
      do_reset();
      for (int i = 0; i < 5; i++) do_step(1, 2);
`ifdef WALL_KILL_EN
      chk("wall_kill_go", game_over, 1);
      chk("wall_kill_head", head, 6'o74);
`else
      chk("wrap_head", head, 6'o04);
      chk("wrap_go", game_over, 0);
`endif
      do_reset();
      do_step(1, 1);
      do_step(1, 1);
      chk("u_len", length, 5);
      do_step(2, 2);
      do_step(3, 2);
      do_step(0, 2);
      chk("u_dead", game_over, 1);
      chk("u_len_kept", length, 5);
      do_step(1, 0);
      do_reset();
      dir = 2'd1;
      step = 1'b1;
      tick;
      step = 1'b0;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      model_reset();
      chk("rst_move_head", head, 6'o34);
      chk("rst_move_len", length, 3);
      chk("rst_move_gen", gen, 0);
      chk("rst_move_go", game_over, 0);
      do_step(1, 2);
      chk("after_rst_move", head, 6'o44);
      do_reset();
      foreach (path[i]) do_step(path[i], 1);
      chk("sat_len", length, MAX);
      do_reset();
      for (int n = 0; n < 150; n++) begin
         do_step(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0 ? 1 : 0);
         if (dead_m) begin
            do_step(int'($urandom_range(0, 3)), 0);
            do_reset();
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Snake movement/growth engine for the 8x8 playfield.
- Holds the segment list and advances the head one cell per `step` tick.
- Detects when the head lands on the food cell and pulses `gen` to the food generator, which returns a fresh `food` position. It also detects self-collision.
- Sits between the input/tick logic (upstream) and the food generator and display (downstream).

Parameters:
- MAX_LEN, 16, capacity of the segment buffer (max snake length, power of 2).
- START_LEN, 3, length after reset (2..MAX_LEN).
- START_X, 3, head x after reset (0..7).
- START_Y, 4, head y after reset (0..7).

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- step  in  1  move tick; one-cycle pulse, sampled only in RUN.
- dir  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- food  in  7  food position: [5:3]=x, [2:0]=y, [6] ignored.
- gen  out  1  one-cycle pulse requesting new food.
- head  out  6  current head {x[2:0], y[2:0]}.
- length  out  5  current length (START_LEN..MAX_LEN).
- seg_addr  in  4  display read index (0 = head).
- seg_pos  out  6  combinational read of seg[seg_addr]; valid when seg_addr < length.
- seg_valid  out  1  seg_addr < length.
- game_over  out  1  high in DEAD.

Behaviour:
- Reset (RST=1 at posedge, from any state, mid-move included):
  - State goes to RUN; seg[i]={START_X-i mod 8, START_Y} for all i < MAX_LEN.
  - cur_dir=right, length=START_LEN, gen=0, game_over=0.
- State machine:
  - RUN -> MOVE when step=1; otherwise stay in RUN.
  - MOVE -> CHECK unconditionally.
  - CHECK -> DEAD on collision, else RUN.
  - DEAD is terminal until RST.
- Step handling:
  - step outside RUN is dropped, not queued.
  - Latency is 3 cycles from step accepted to RUN again, with head valid at MOVE+1.
- Direction latch (RUN, on step):
  - cur_dir<=dir unless dir is the exact reverse of cur_dir; a reverse is ignored and cur_dir is kept.
- MOVE:
  - nxt = head moved one cell in cur_dir, using 3-bit wrap-around (x=7 right -> 0, y=0 up -> 7).
  - seg[i]<=seg[i-1] for 1<=i<MAX_LEN, and seg[0]<=nxt.
  - The old tail stays at index old length, so growth only needs to expose it.
- CHECK, with L = length before this step:
  - eat = (seg[0]==food[5:0]).
  - hit = seg[0]==seg[i] for any 1<=i<L.
  - hit=1 -> DEAD, game_over=1, gen stays 0, length unchanged.
  - Else eat=1 -> gen=1 for exactly the next cycle; length<=L+1 saturating at MAX_LEN (at MAX_LEN gen still pulses).
  - Else nothing changes.
- gen:
  - Registered, high for one cycle only, never high in two consecutive cycles.
  - The next gen can come no earlier than 3 cycles later.
- Arithmetic:
  - length is 5 bits; compare against MAX_LEN before increment.
  - Position compares are 6-bit equality.
- food is sampled only in CHECK; changes at other times have no effect.

Optional Feature:
- WALL_KILL_EN defined:
  - A move leaving 0..7 on either axis (x=7 right, x=0 left, y=0 up, y=7 down) goes MOVE -> DEAD directly.
  - In that case seg is not shifted, head keeps its edge value, and gen=0.
- Undefined: wrap-around as above.

Decomposition:
- snake_pkg holds:
  - direction codes DIR_UP/RIGHT/DOWN/LEFT.
  - POS_W=6 and COORD_W=3.
  - state encoding RUN/MOVE/CHECK/DEAD.
  - helper constant GRID_MAX=7.
- Sub-module snake_next_pos (combinational):
  - Inputs head and cur_dir; outputs nxt and out_of_bounds.
  - out_of_bounds is used only under WALL_KILL_EN.

Test Plan:
- Reset defaults -> head=6'o34 ({3,4}), length=3, seg[1]={2,4}, seg[2]={1,4}, gen=0, game_over=0.
- food={0,5,4} (x=5,y=4), two steps dir=right -> after second CHECK: head={5,4}, gen one-cycle pulse, length=4, seg[3]={2,4}.
- Head {3,4} moving right, step with dir=left -> reverse ignored, head={4,4}; then dir=up step -> head={4,3}.
- Head x=7, dir=right, step -> head={0,y} without macro. With WALL_KILL_EN: game_over=1 and head stays {7,y}.
- Length 5 in a U (right, down, left, up sequence) -> head hits seg[3], DEAD, game_over=1; further steps ignored; RST -> defaults restored.
- step pulses on consecutive cycles -> only the first is accepted (one move per 3 cycles); RST asserted during MOVE -> next cycle at reset values, gen=0.
